// File: rtl/branch_predict_unit_pkg.sv
// rtl/branch_predict_unit_pkg.sv - shared instruction-type encodings and predictor constants
package branch_predict_unit_pkg;

   // {is_branch, is_jalr} as delivered by the EX stage
   typedef enum logic [1:0] {
      INST_TYPE_NONE   = 2'b00,
      INST_TYPE_JALR   = 2'b01,
      INST_TYPE_BRANCH = 2'b10
   } inst_type_e;

   // BHT counter value after reset: weakly not-taken
   localparam logic [1:0] BHT_WEAK_NT = 2'b01;

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// rtl/branch_predict_unit_sat_counter.sv - 2-bit saturating up/down counter cell (bpu_sat_counter)
module bpu_sat_counter
   import branch_predict_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       dec,
   output logic [1:0] ctr
);

   // count toward strongly-taken on inc, strongly-not-taken on dec, clamping at both ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr <= BHT_WEAK_NT;
      end else if (inc && (ctr != 2'b11)) begin
         ctr <= ctr + 2'b01;
      end else if (dec && (ctr != 2'b00)) begin
         ctr <= ctr - 2'b01;
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BHT/BTB branch predictor with mispredict redirect; optional BPU_PERF_CNT_EN counters
module branch_predict_unit
   import branch_predict_unit_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [1:0]  ex_inst_type,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        flush,
   output logic [31:0] redirect_pc
`ifdef BPU_PERF_CNT_EN
   ,
   output logic [31:0] perf_br_cnt,
   output logic [31:0] perf_miss_cnt
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);

   logic [IDX_W-1:0]   if_idx;
   logic [IDX_W-1:0]   ex_idx;
   logic [TAG_W-1:0]   if_tag;
   logic [TAG_W-1:0]   ex_tag;

   logic [1:0]         bht [ENTRIES];
   logic [ENTRIES-1:0] btb_valid;
   logic [ENTRIES-1:0] btb_jalr;
   logic [TAG_W-1:0]   btb_tag    [ENTRIES];
   logic [31:0]        btb_target [ENTRIES];

   logic               if_hit;
   logic               is_branch;
   logic               is_jalr;
   logic               actual_taken;
   logic               mispredict;
   logic               btb_write;
   logic               btb_inval;

   // address bits that never reach the index or tag
   logic               unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[31:IDX_W+TAG_W+2], if_pc[1:0], ex_pc[1:0]};

   assign if_idx = if_pc[IDX_W+1:2];
   assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

   // fetch-side lookup: jalr entries always predict taken, branches follow the counter MSB
   always_comb begin
      if_hit      = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
      pred_taken  = if_hit && (btb_jalr[if_idx] || bht[if_idx][1]);
      pred_target = if_hit ? btb_target[if_idx] : 32'd0;
   end

   // EX-side resolve: compare the carried prediction with the real outcome
   always_comb begin
      is_branch    = 1'b0;
      is_jalr      = 1'b0;
      actual_taken = 1'b0;
      mispredict   = 1'b0;
      case (ex_inst_type)
         INST_TYPE_BRANCH: begin
            is_branch    = 1'b1;
            actual_taken = ex_taken;
            mispredict   = (ex_taken != ex_pred_taken) ||
                           (ex_taken && (ex_target != ex_pred_target));
         end
         INST_TYPE_JALR: begin
            is_jalr      = 1'b1;
            actual_taken = 1'b1;
            mispredict   = !ex_pred_taken || (ex_target != ex_pred_target);
         end
         default: begin
            // a non-control instruction predicted taken hit a stale aliased BTB entry
            mispredict   = ex_pred_taken;
         end
      endcase
      // rst_n term lets flush drop immediately when reset asserts mid-cycle
      flush       = rst_n && ex_valid && mispredict;
      redirect_pc = actual_taken ? ex_target : (ex_pc + 32'd4);
      btb_write   = ex_valid && ((is_branch && ex_taken) || is_jalr);
      btb_inval   = ex_valid && (ex_inst_type == INST_TYPE_NONE) && ex_pred_taken;
   end

   genvar g;
   for (g = 0; g < ENTRIES; g++) begin : g_bht
      bpu_sat_counter u_ctr (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (ex_valid && is_branch && ex_taken  && (ex_idx == IDX_W'(g))),
         .dec   (ex_valid && is_branch && !ex_taken && (ex_idx == IDX_W'(g))),
         .ctr   (bht[g])
      );
   end

   // BTB valid bits: set on taken branch / jalr, cleared when a stale alias is detected
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btb_valid <= '0;
      end else if (btb_write) begin
         btb_valid[ex_idx] <= 1'b1;
      end else if (btb_inval) begin
         btb_valid[ex_idx] <= 1'b0;
      end
   end

   // BTB payload needs no reset: it is only visible through a set valid bit
   always_ff @(posedge clk) begin
      if (btb_write) begin
         btb_tag[ex_idx]    <= ex_tag;
         btb_target[ex_idx] <= ex_target;
         btb_jalr[ex_idx]   <= is_jalr;
      end
   end

`ifdef BPU_PERF_CNT_EN
   // control-flow instruction and mispredict event counters, free-running with wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_br_cnt   <= 32'd0;
         perf_miss_cnt <= 32'd0;
      end else begin
         if (ex_valid && (ex_inst_type != INST_TYPE_NONE)) begin
            perf_br_cnt <= perf_br_cnt + 32'd1;
         end
         if (flush) begin
            perf_miss_cnt <= perf_miss_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit against a table model
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] if_pc = 32'd0;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_pc = 32'd0;
   logic [1:0]  ex_inst_type = 2'b00;
   logic        ex_taken = 1'b0;
   logic [31:0] ex_target = 32'd0;
   logic        ex_pred_taken = 1'b0;
   logic [31:0] ex_pred_target = 32'd0;
   logic        flush;
   logic [31:0] redirect_pc;
`ifdef BPU_PERF_CNT_EN
   logic [31:0] perf_br_cnt;
   logic [31:0] perf_miss_cnt;
`endif

   always #5 clk = ~clk;

   branch_predict_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .ex_inst_type   (ex_inst_type),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .flush          (flush),
      .redirect_pc    (redirect_pc)
`ifdef BPU_PERF_CNT_EN
      ,
      .perf_br_cnt    (perf_br_cnt),
      .perf_miss_cnt  (perf_miss_cnt)
`endif
   );

   typedef struct {
      int          cyc;
      logic        pt;
      logic [31:0] ptgt;
      logic        fl;
      logic [31:0] rd;
      logic [31:0] br;
      logic [31:0] miss;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   done = 1'b0;

   // reference model: 16 entries, index = (pc>>2)%16, tag = (pc>>6)%256
   int          m_ctr   [16];
   bit          m_valid [16];
   bit          m_jalr  [16];
   int          m_tag   [16];
   logic [31:0] m_tgt   [16];
   logic [31:0] m_br;
   logic [31:0] m_miss;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % 32'd16);
   endfunction

   function automatic int tag_of(input logic [31:0] pc);
      return int'((pc >> 6) % 32'd256);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_ctr[i]   = 1;
         m_valid[i] = 1'b0;
         m_jalr[i]  = 1'b0;
         m_tag[i]   = 0;
         m_tgt[i]   = 32'd0;
      end
      m_br   = 32'd0;
      m_miss = 32'd0;
   endtask

   task automatic model_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
      int  i;
      bit  hit;
      i   = idx_of(pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(pc));
      t   = hit && (m_jalr[i] || (m_ctr[i] >= 2));
      tg  = hit ? m_tgt[i] : 32'd0;
   endtask

   task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", nm, c, act, exp);
      end
   endtask

   // one stimulus cycle: apply inputs just after the edge, queue the expectation, advance the model
   task automatic drive(input bit rst, input bit v, input logic [31:0] pc, input logic [1:0] typ,
                        input bit tk, input logic [31:0] tgt, input bit ptk,
                        input logic [31:0] ptgt, input logic [31:0] ipc);
      exp_t e;
      bit   act, mis;
      int   i;
      @(posedge clk);
      #1;
      cyc++;
      rst_n          = !rst;
      ex_valid       = v;
      ex_pc          = pc;
      ex_inst_type   = typ;
      ex_taken       = tk;
      ex_target      = tgt;
      ex_pred_taken  = ptk;
      ex_pred_target = ptgt;
      if_pc          = ipc;
      if (rst) model_reset();
      e.cyc  = cyc;
      model_lookup(ipc, e.pt, e.ptgt);
      case (typ)
         2'b10:   begin act = tk;   mis = (tk != ptk) || (tk && (tgt != ptgt)); end
         2'b01:   begin act = 1'b1; mis = !ptk || (tgt != ptgt); end
         default: begin act = 1'b0; mis = ptk; end
      endcase
      e.fl   = !rst && v && mis;
      e.rd   = act ? tgt : pc + 32'd4;
      e.br   = m_br;
      e.miss = m_miss;
      exp_q.push_back(e);
      if (!rst && v) begin
         i = idx_of(pc);
         if (typ != 2'b00) m_br = m_br + 32'd1;
         if (e.fl) m_miss = m_miss + 32'd1;
         if (typ == 2'b10) begin
            m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
         end
         if ((typ == 2'b10 && tk) || typ == 2'b01) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(pc);
            m_tgt[i]   = tgt;
            m_jalr[i]  = (typ == 2'b01);
         end else if (typ == 2'b00 && ptk) begin
            m_valid[i] = 1'b0;
         end
      end
   endtask

   // monitor: the outputs are combinational, so one expectation is consumed every cycle
   initial begin
      exp_t e;
      while (!done) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pred_taken", e.cyc, {31'd0, pred_taken}, {31'd0, e.pt});
            chk("pred_target", e.cyc, pred_target, e.ptgt);
            chk("flush", e.cyc, {31'd0, flush}, {31'd0, e.fl});
            if (e.fl) chk("redirect_pc", e.cyc, redirect_pc, e.rd);
`ifdef BPU_PERF_CNT_EN
            chk("perf_br_cnt", e.cyc, perf_br_cnt, e.br);
            chk("perf_miss_cnt", e.cyc, perf_miss_cnt, e.miss);
`endif
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pc, ipc, tgt, ptgt;
      logic [1:0]  typ;
      logic        ptk;
      model_reset();
      // reset state
      drive(1, 0, 32'h0, 2'b00, 0, 32'h0, 0, 32'h0, 32'h100);
      drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 0, 32'h0, 32'h100);
      // first taken branch mispredicts, then is predicted taken
      drive(0, 1, 32'h100, 2'b10, 1, 32'h180, 0, 32'h0, 32'h100);
      drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 0, 32'h0, 32'h100);
      // saturate then one not-taken: counter leaves 11, prediction stays taken
      for (int k = 0; k < 3; k++) drive(0, 1, 32'h100, 2'b10, 1, 32'h180, 1, 32'h180, 32'h100);
      drive(0, 1, 32'h100, 2'b10, 0, 32'h180, 1, 32'h180, 32'h100);
      drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 0, 32'h0, 32'h100);
      // jalr: cold miss, then correct prediction
      drive(0, 1, 32'h200, 2'b01, 0, 32'h340, 0, 32'h0, 32'h200);
      drive(0, 1, 32'h200, 2'b01, 0, 32'h340, 1, 32'h340, 32'h200);
      // bubble with mismatching inputs, then 32-bit wrap of the fall-through
      drive(0, 0, 32'h100, 2'b10, 0, 32'h999, 1, 32'h180, 32'h100);
      drive(0, 1, 32'hFFFF_FFFC, 2'b10, 0, 32'h40, 1, 32'h40, 32'h100);
      // stale alias of a non-control instruction invalidates the entry
      drive(0, 1, 32'h140, 2'b00, 0, 32'h0, 1, 32'h180, 32'h140);
      drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 0, 32'h0, 32'h140);
      // same index updated and looked up in one cycle sees old contents
      drive(0, 1, 32'h208, 2'b10, 1, 32'h500, 0, 32'h0, 32'h208);
      drive(0, 1, 32'h208, 2'b10, 1, 32'h600, 1, 32'h500, 32'h208);
      drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 0, 32'h0, 32'h208);
      // reset mid-run with a mispredicting instruction present
      drive(1, 1, 32'h200, 2'b01, 0, 32'h340, 0, 32'h0, 32'h200);
      drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 0, 32'h0, 32'h200);
      // randomized traffic over a small aliasing PC space
      for (int n = 0; n < 600; n++) begin
         pc  = 32'h1000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         typ = 2'($urandom_range(0, 2));
         tgt = 32'h2000 + ($urandom_range(0, 3) * 32'h40);
         if ($urandom_range(0, 1) == 1) begin
            model_lookup(pc, ptk, ptgt);
         end else begin
            ptk  = 1'($urandom_range(0, 1));
            ptgt = 32'h2000 + ($urandom_range(0, 3) * 32'h40);
         end
         ipc = ($urandom_range(0, 2) == 0) ? pc :
               32'h1000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, pc, typ,
               1'($urandom_range(0, 1)), tgt, ptk, ptgt, ipc);
      end
      drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 0, 32'h0, 32'h0);
      @(posedge clk);
      @(posedge clk);
      done = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
